// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and types for the data memory responder
package mem_pkg;

   // Access-size encodings carried on req_type
   localparam logic [1:0] TYPE_WORD = 2'b00;
   localparam logic [1:0] TYPE_HALF = 2'b01;
   localparam logic [1:0] TYPE_BYTE = 2'b10;
   localparam logic [1:0] TYPE_ILL  = 2'b11;

   // Latency counter width: LATENCY is limited to 0..15
   localparam int LAT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // Request fields captured at the accept edge
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  acc_type;
      logic        sign_ext;
   } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, store masking and load extension
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  acc_type,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   input  logic        sign_ext,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_sh,
   output logic        misalign,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store path: replicate right-aligned data to every lane, strobe picks the lane(s)
   always_comb begin
      wstrb    = 4'b0000;
      wdata_sh = '0;
      misalign = 1'b0;
      case (acc_type)
         TYPE_WORD: begin
            wstrb    = 4'b1111;
            wdata_sh = wdata;
            misalign = (addr_lo != 2'b00);
         end
         TYPE_HALF: begin
            wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[15:0]}};
            misalign = addr_lo[0];
         end
         TYPE_BYTE: begin
            wstrb    = 4'b0001 << addr_lo;
            wdata_sh = {4{wdata[7:0]}};
         end
         default: ;
      endcase
   end

   // Load path: select the addressed lane(s) and extend to 32 bits
   always_comb begin
      byte_sel  = rdata_raw[8*addr_lo +: 8];
      half_sel  = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
      rdata_ext = rdata_raw;
      case (acc_type)
         TYPE_HALF: rdata_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
         TYPE_BYTE: rdata_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store memory responder with programmable latency
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 17,
   parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
   parameter int          LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [1:0]            req_type,
   input  logic                  req_sign_ext,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err
);

   localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

   state_t                 state_q, state_d;
   logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   req_ready_q, req_ready_d;
   logic                   resp_valid_q, resp_valid_d;
   logic [31:0]            resp_rdata_q, resp_rdata_d;
   logic                   resp_err_q, resp_err_d;
   req_t                   req_q, req_d;
   logic [31:0]            ram_q [DEPTH];

   req_t                   acc;
   logic [31:0]            offset;
   logic [ADDR_WIDTH-3:0]  word_idx;
   logic                   in_range;
   logic [3:0]             wstrb;
   logic [31:0]            wdata_sh;
   logic [31:0]            rdata_ext;
   logic                   misalign;
   logic                   acc_err;
   logic                   do_access;
   logic                   ram_we;

   // Zero latency accesses straight from the request pins; otherwise from the latch
   always_comb begin
      if (state_q == IDLE) begin
         acc = '{write: req_write, addr: req_addr, wdata: req_wdata,
                 acc_type: req_type, sign_ext: req_sign_ext};
      end else begin
         acc = req_q;
      end
      offset   = acc.addr - BASE_ADDR;
      word_idx = offset[ADDR_WIDTH-1:2];
      in_range = (acc.addr >= BASE_ADDR) && (offset[31:ADDR_WIDTH] == '0);
      acc_err  = misalign || (acc.acc_type == TYPE_ILL) || !in_range;
   end

   mem_lane_align u_align (
      .addr_lo   (offset[1:0]),
      .acc_type  (acc.acc_type),
      .wdata     (acc.wdata),
      .rdata_raw (ram_q[word_idx]),
      .sign_ext  (acc.sign_ext),
      .wstrb     (wstrb),
      .wdata_sh  (wdata_sh),
      .misalign  (misalign),
      .rdata_ext (rdata_ext)
   );

   // Next-state, latency countdown and response capture
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      req_d        = req_q;
      do_access    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               req_d       = acc;
               req_ready_d = 1'b0;
               if (LATENCY == 0) begin
                  do_access = 1'b1;
                  state_d   = RESP;
               end else begin
                  cnt_d   = LAT_CNT_W'(LATENCY - 1);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               do_access = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (do_access) begin
         resp_valid_d = 1'b1;
         resp_err_d   = acc_err;
         resp_rdata_d = (acc_err || acc.write) ? '0 : rdata_ext;
      end
   end

   assign ram_we = do_access && acc.write && !acc_err;

   // Control and response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         req_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         req_q        <= req_d;
      end
   end

   // RAM array, byte-masked writes, contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) ram_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

   localparam int         LAT    = 2;
   localparam logic [1:0] T_WORD = 2'b00;
   localparam logic [1:0] T_HALF = 2'b01;
   localparam logic [1:0] T_BYTE = 2'b10;
   localparam logic [1:0] T_ILL  = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_type = '0;
   logic        req_sign_ext = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      string       name;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  t;
      logic        s;
      logic [31:0] er;
      logic        ee;
   } txn_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   data_mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (17),
      .BASE_ADDR  (32'h0001_0000),
      .LATENCY    (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_type     (req_type),
      .req_sign_ext (req_sign_ext),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   function automatic txn_t mk(string n, logic w, logic [31:0] a, logic [31:0] wd,
                               logic [1:0] t, logic s, logic [31:0] er, logic ee);
      txn_t x;
      x.name = n; x.w = w; x.a = a; x.wd = wd; x.t = t; x.s = s; x.er = er; x.ee = ee;
      return x;
   endfunction

   // Drive one request, measure edges from accept to resp_valid, then take the response
   task automatic drive_txn(input txn_t x, output logic [31:0] rd, output logic er, output int lat);
      int k;
      req_valid = 1'b1; req_write = x.w; req_addr = x.a; req_wdata = x.wd;
      req_type = x.t; req_sign_ext = x.s;
      k = 0;
      while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
      if (!req_ready) begin
         req_valid = 1'b0; rd = 'x; er = 1'bx; lat = -1;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr = $urandom(); req_wdata = $urandom(); req_type = 2'($urandom());
      req_write = ~x.w; req_sign_ext = ~x.s;
      lat = 0;
      while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      if (!resp_valid) begin
         rd = 'x; er = 1'bx; lat = -1;
         return;
      end
      rd = resp_rdata; er = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      bit seen;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", req_ready); else n_pass++;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", resp_valid); else n_pass++;
      n_checks++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); else n_pass++;
      n_checks++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got %b exp 0", resp_err); else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL rel_req_ready_early got %b exp 0", req_ready); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (req_ready !== 1'b1) $display("FAIL rel_req_ready got %b exp 1", req_ready); else n_pass++;
      seen = 1'b0;
      repeat (5) begin @(posedge clk); #1; if (resp_valid !== 1'b0) seen = 1'b1; end
      n_checks++; if (seen) $display("FAIL idle_resp_valid got 1 exp 0"); else n_pass++;
   endtask

   task automatic test_word_roundtrip();
      txn_t tbl[$];
      exp_t e;
      logic [31:0] rd;
      logic er;
      int lat;
      tbl.push_back(mk("st_word", 1'b1, 32'h0001_0004, 32'hDEADBEEF, T_WORD, 1'b0, 32'h0, 1'b0));
      tbl.push_back(mk("ld_word", 1'b0, 32'h0001_0004, 32'h0, T_WORD, 1'b0, 32'hDEADBEEF, 1'b0));
      foreach (tbl[i]) begin
         sb_q.push_back('{tbl[i].er, tbl[i].ee});
         drive_txn(tbl[i], rd, er, lat);
         e = sb_q.pop_front();
         n_checks++; if (rd !== e.rdata) $display("FAIL %s rdata got %h exp %h", tbl[i].name, rd, e.rdata); else n_pass++;
         n_checks++; if (er !== e.err) $display("FAIL %s err got %b exp %b", tbl[i].name, er, e.err); else n_pass++;
         n_checks++; if (lat !== LAT) $display("FAIL %s latency got %0d exp %0d", tbl[i].name, lat, LAT); else n_pass++;
      end
   endtask

   task automatic test_subword();
      txn_t tbl[$];
      exp_t e;
      logic [31:0] rd;
      logic er;
      int lat;
      tbl.push_back(mk("st_byte",    1'b1, 32'h0001_0007, 32'h0000_0080, T_BYTE, 1'b0, 32'h0, 1'b0));
      tbl.push_back(mk("ld_w_byte",  1'b0, 32'h0001_0004, 32'h0, T_WORD, 1'b0, 32'h80ADBEEF, 1'b0));
      tbl.push_back(mk("ld_b_sext",  1'b0, 32'h0001_0007, 32'h0, T_BYTE, 1'b1, 32'hFFFFFF80, 1'b0));
      tbl.push_back(mk("ld_b_zext",  1'b0, 32'h0001_0007, 32'h0, T_BYTE, 1'b0, 32'h00000080, 1'b0));
      tbl.push_back(mk("ld_b_lane1", 1'b0, 32'h0001_0005, 32'h0, T_BYTE, 1'b1, 32'hFFFFFFBE, 1'b0));
      tbl.push_back(mk("st_half",    1'b1, 32'h0001_0006, 32'hFFFF_1234, T_HALF, 1'b0, 32'h0, 1'b0));
      tbl.push_back(mk("ld_w_half",  1'b0, 32'h0001_0004, 32'h0, T_WORD, 1'b1, 32'h1234BEEF, 1'b0));
      tbl.push_back(mk("ld_h_lo_s",  1'b0, 32'h0001_0004, 32'h0, T_HALF, 1'b1, 32'hFFFFBEEF, 1'b0));
      tbl.push_back(mk("ld_h_lo_u",  1'b0, 32'h0001_0004, 32'h0, T_HALF, 1'b0, 32'h0000BEEF, 1'b0));
      tbl.push_back(mk("ld_h_hi_s",  1'b0, 32'h0001_0006, 32'h0, T_HALF, 1'b1, 32'h00001234, 1'b0));
      foreach (tbl[i]) begin
         sb_q.push_back('{tbl[i].er, tbl[i].ee});
         drive_txn(tbl[i], rd, er, lat);
         e = sb_q.pop_front();
         n_checks++; if (rd !== e.rdata) $display("FAIL %s rdata got %h exp %h", tbl[i].name, rd, e.rdata); else n_pass++;
         n_checks++; if (er !== e.err) $display("FAIL %s err got %b exp %b", tbl[i].name, er, e.err); else n_pass++;
         n_checks++; if (lat !== LAT) $display("FAIL %s latency got %0d exp %0d", tbl[i].name, lat, LAT); else n_pass++;
      end
   endtask

   task automatic test_errors();
      txn_t tbl[$];
      exp_t e;
      logic [31:0] rd;
      logic er;
      int lat;
      tbl.push_back(mk("ld_w_mis",    1'b0, 32'h0001_0002, 32'h0, T_WORD, 1'b0, 32'h0, 1'b1));
      tbl.push_back(mk("st_h_mis",    1'b1, 32'h0001_0005, 32'h0000_FFFF, T_HALF, 1'b0, 32'h0, 1'b1));
      tbl.push_back(mk("ld_after_bad",1'b0, 32'h0001_0004, 32'h0, T_WORD, 1'b0, 32'h1234BEEF, 1'b0));
      tbl.push_back(mk("st_w_mis",    1'b1, 32'h0001_0006, 32'h5555_5555, T_WORD, 1'b0, 32'h0, 1'b1));
      tbl.push_back(mk("ld_after_bw", 1'b0, 32'h0001_0004, 32'h0, T_WORD, 1'b0, 32'h1234BEEF, 1'b0));
      tbl.push_back(mk("ld_zero",     1'b0, 32'h0000_0000, 32'h0, T_WORD, 1'b0, 32'h0, 1'b1));
      tbl.push_back(mk("ld_below",    1'b0, 32'h0000_FFFC, 32'h0, T_WORD, 1'b0, 32'h0, 1'b1));
      tbl.push_back(mk("ld_type11",   1'b0, 32'h0001_0004, 32'h0, T_ILL,  1'b0, 32'h0, 1'b1));
      tbl.push_back(mk("st_top",      1'b1, 32'h0002_FFFC, 32'hA55A_0FF0, T_WORD, 1'b0, 32'h0, 1'b0));
      tbl.push_back(mk("ld_top",      1'b0, 32'h0002_FFFC, 32'h0, T_WORD, 1'b0, 32'hA55A0FF0, 1'b0));
      tbl.push_back(mk("ld_past_top", 1'b0, 32'h0003_0000, 32'h0, T_WORD, 1'b0, 32'h0, 1'b1));
      foreach (tbl[i]) begin
         sb_q.push_back('{tbl[i].er, tbl[i].ee});
         drive_txn(tbl[i], rd, er, lat);
         e = sb_q.pop_front();
         n_checks++; if (rd !== e.rdata) $display("FAIL %s rdata got %h exp %h", tbl[i].name, rd, e.rdata); else n_pass++;
         n_checks++; if (er !== e.err) $display("FAIL %s err got %b exp %b", tbl[i].name, er, e.err); else n_pass++;
         n_checks++; if (lat !== LAT) $display("FAIL %s latency got %0d exp %0d", tbl[i].name, lat, LAT); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int k;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0001_0004;
      req_type = T_WORD; req_sign_ext = 1'b0;
      sb_q.push_back('{32'h1234BEEF, 1'b0});
      k = 0;
      while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      // second request presented immediately and held through the stall
      req_addr = 32'h0001_0004; req_type = T_BYTE; req_sign_ext = 1'b0;
      sb_q.push_back('{32'h000000EF, 1'b0});
      k = 0;
      while (!resp_valid && k < 40) begin @(posedge clk); #1; k++; end
      n_checks++; if (k !== LAT) $display("FAIL bp_first_latency got %0d exp %0d", k, LAT); else n_pass++;
      e = sb_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, e.err, e.rdata})
            $display("FAIL bp_hold_%0d got v=%b rdy=%b err=%b rdata=%h exp v=1 rdy=0 err=%b rdata=%h",
                     c, resp_valid, req_ready, resp_err, resp_rdata, e.err, e.rdata);
         else n_pass++;
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      n_checks++;
      if ({resp_valid, req_ready} !== 2'b01)
         $display("FAIL bp_after_xfer got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_second_accept got rdy=%b exp 0", req_ready); else n_pass++;
      req_valid = 1'b0; req_addr = 32'h0001_0006; req_type = T_WORD;
      k = 0;
      while (!resp_valid && k < 40) begin @(posedge clk); #1; k++; end
      e = sb_q.pop_front();
      n_checks++; if (k !== LAT) $display("FAIL bp_second_latency got %0d exp %0d", k, LAT); else n_pass++;
      n_checks++;
      if ({resp_err, resp_rdata} !== {e.err, e.rdata})
         $display("FAIL bp_second_resp got err=%b rdata=%h exp err=%b rdata=%h", resp_err, resp_rdata, e.err, e.rdata);
      else n_pass++;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      exp_t e;
      logic [31:0] rd;
      logic er;
      int lat;
      int k;
      bit seen;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0001_0004;
      req_wdata = 32'h1111_1111; req_type = T_WORD; req_sign_ext = 1'b0;
      k = 0;
      while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({resp_valid, req_ready} !== 2'b00)
         $display("FAIL rmw_async got v=%b rdy=%b exp v=0 rdy=0", resp_valid, req_ready);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; if (resp_valid !== 1'b0) seen = 1'b1; end
      n_checks++; if (seen) $display("FAIL rmw_stale_resp got 1 exp 0"); else n_pass++;
      sb_q.push_back('{32'h1234BEEF, 1'b0});
      drive_txn(mk("rmw_load", 1'b0, 32'h0001_0004, 32'h0, T_WORD, 1'b0, 32'h0, 1'b0), rd, er, lat);
      e = sb_q.pop_front();
      n_checks++; if (rd !== e.rdata) $display("FAIL rmw_load rdata got %h exp %h", rd, e.rdata); else n_pass++;
      n_checks++; if (er !== e.err) $display("FAIL rmw_load err got %b exp %b", er, e.err); else n_pass++;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word_roundtrip();
      test_subword();
      test_errors();
      test_backpressure();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
